uart_tx_fifo: RTL

- Buffered UART transmitter. The outbound counterpart to the receive path of our serial link.
- Accepts bytes from on-chip logic via a valid/ready handshake and stores them in a small FIFO.
- Serializes them onto the tx pin as 8N1 frames with its own baud timer.
- Sits between a response/echo generator and the board's USB-UART tx pin, so producers never wait per byte.

---
 rtl/uart_tx_fifo.sv | 102 ++++++++++
 1 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a valid/ready byte FIFO.
module uart_tx_fifo #(
  parameter int CLK_FREQUENCY = 100000000,
  parameter int BAUD_RATE = 115200,
  parameter int FIFO_DEPTH = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic [7:0] tx_data,
  input  logic tx_valid,
  output logic tx_ready,
  output logic tx,
  output logic tx_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count
);
  localparam int DIV = CLK_FREQUENCY / BAUD_RATE;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(DIV + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state_q, state_d;
  logic [7:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shift_q, shift_d;
  logic tx_q, tx_d, push, pop, tick, nonempty;
  assign tx_ready = cnt_q < CW'(FIFO_DEPTH);
  assign push = tx_valid && tx_ready;
  assign nonempty = cnt_q != '0;
  assign tick = baud_q == BW'(DIV - 1);
  assign tx = tx_q;
  assign tx_busy = (state_q != IDLE) || nonempty;
  assign fifo_count = cnt_q;
  always_comb begin
    state_d = state_q;
    baud_d = (state_q == IDLE || tick) ? '0 : baud_q + BW'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    tx_d = tx_q;
    pop = 1'b0;
    case (state_q)
      IDLE: if (nonempty) begin
        pop = 1'b1;
        shift_d = mem_q[rd_q];
        tx_d = 1'b0;
        state_d = START;
      end
      START: if (tick) begin
        tx_d = shift_q[0];
        bit_d = '0;
        state_d = DATA;
      end
      DATA: if (tick) begin
        if (bit_q == 3'd7) begin
          tx_d = 1'b1;
          state_d = STOP;
        end else begin
          shift_d = {1'b0, shift_q[7:1]};
          tx_d = shift_q[1];
          bit_d = bit_q + 3'd1;
        end
      end
      STOP: if (tick) begin
        // Chain straight into the next start bit so queued frames leave no idle gap
        pop = nonempty;
        shift_d = nonempty ? mem_q[rd_q] : shift_q;
        tx_d = !nonempty;
        state_d = nonempty ? START : IDLE;
      end
      default: state_d = IDLE;
    endcase
    wr_d = push ? wr_q + AW'(1) : wr_q;
    rd_d = pop ? rd_q + AW'(1) : rd_q;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      tx_q <= 1'b1;
    end else begin
      state_q <= state_d;
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      tx_q <= tx_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= tx_data;
  end
endmodule
